// File: rtl/ula_issue_if.sv
// ula_issue_if: instruction handshake, ULA operand/result, retire status and debug-read
// signals of the issue/writeback controller.
interface ula_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] instr;
    logic [3:0]  ula_op1;
    logic [3:0]  ula_op2;
    logic [3:0]  ula_opcode;
    logic [7:0]  ula_result;
    logic        done;
    logic [7:0]  wb_data;
    logic        flag_zero;
    logic        flag_hi;
    logic        flag_div0;
    logic [1:0]  dbg_addr;
    logic [3:0]  dbg_data;

    modport slave (
        input  in_valid, instr, ula_result, dbg_addr,
        output in_ready, ula_op1, ula_op2, ula_opcode, done, wb_data,
               flag_zero, flag_hi, flag_div0, dbg_data
    );

    modport master (
        output in_valid, instr, ula_result, dbg_addr,
        input  in_ready, ula_op1, ula_op2, ula_opcode, done, wb_data,
               flag_zero, flag_hi, flag_div0, dbg_data
    );
endinterface

// File: rtl/ula_issue.sv
// ula_issue: accepts one instruction, drives the external combinational ULA, then writes
// the low result nibble back to rd and the high nibble to HI (IDLE -> EXEC -> WB).
module ula_issue #(
    parameter int         NUM_REGS  = 4,
    parameter logic [3:0] RESET_VAL = 4'h0,
    parameter logic [3:0] ULA_DIV   = 4'h3
) (
    input logic        clock,
    input logic        reset,
    ula_issue_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                   state_q, state_d;
    logic [NUM_REGS-1:0][3:0] regs_q, regs_d;
    logic [3:0]               hi_q, hi_d, op1_q, op1_d, op2_q, op2_d, opc_q, opc_d;
    logic [AW-1:0]            rd_q, rd_d;
    logic [7:0]               res_q, res_d, wb_q, wb_d;
    logic                     fz_q, fz_d, fh_q, fh_d, fd_q, fd_d;
    logic                     accept, div0, unused_bits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            regs_q  <= {NUM_REGS{RESET_VAL}};
            hi_q    <= RESET_VAL;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            wb_q    <= '0;
            fz_q    <= 1'b0;
            fh_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            hi_q    <= hi_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            wb_q    <= wb_d;
            fz_q    <= fz_d;
            fh_q    <= fh_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (bus.in_valid ? EXEC : IDLE) :
                  state_q == EXEC ? WB : IDLE;
    end

    always_comb begin
        bus.in_ready = state_q == IDLE;
        bus.done     = state_q == WB;
        accept       = bus.in_ready && bus.in_valid;
    end

    // Operands are captured at accept, so rd aliasing rs1/rs2 sees the pre-write value.
    always_comb begin
        rd_d   = accept ? bus.instr[8 +: AW] : rd_q;
        op1_d  = accept ? regs_q[bus.instr[6 +: AW]] : op1_q;
        op2_d  = accept ? (bus.instr[5] ? bus.instr[3:0] : regs_q[bus.instr[0 +: AW]]) : op2_q;
        opc_d  = accept ? bus.instr[13:10] : opc_q;
        res_d  = state_q == EXEC ? bus.ula_result : res_q;
        div0   = opc_q == ULA_DIV && op2_q == 4'h0;
        regs_d = regs_q;
        hi_d   = hi_q;
        wb_d   = wb_q;
        fz_d   = fz_q;
        fh_d   = fh_q;
        fd_d   = fd_q;
        if (bus.done) begin
            regs_d[rd_q] = div0 ? regs_q[rd_q] : res_q[3:0];
            hi_d         = div0 ? hi_q : res_q[7:4];
            wb_d         = div0 ? 8'h00 : res_q;
            fz_d         = !div0 && res_q == 8'h00;
            fh_d         = !div0 && res_q[7:4] != 4'h0;
            fd_d         = div0;
        end
    end

    // HI has no read port; it and the reserved instruction bit are deliberately unobserved.
    assign unused_bits    = ^{hi_q, bus.instr[4]};
    assign bus.ula_op1    = op1_q;
    assign bus.ula_op2    = op2_q;
    assign bus.ula_opcode = opc_q;
    assign bus.wb_data    = wb_q;
    assign bus.flag_zero  = fz_q;
    assign bus.flag_hi    = fh_q;
    assign bus.flag_div0  = fd_q;
    assign bus.dbg_data   = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_ula_issue.sv
// tb_ula_issue: random and directed instructions against a queue-based scoreboard and a
// register-bank model; an ADD/SUB/MULT/DIV stand-in plays the external ULA.
module tb_ula_issue;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MULT = 4'h2, DIV = 4'h3;

    typedef struct {
        logic [7:0] wb;
        logic       fz;
        logic       fh;
        logic       fd;
        int         due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ula_issue_if bus();
    ula_issue dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    exp_t       q[$];
    logic [3:0] mregs[4];
    int         cyc = 0, n_cmp = 0, n_bad = 0, n_done = 0, n_acc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] ula(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        return op == ADD  ? 8'(a) + 8'(b) :
               op == SUB  ? 8'(a) - 8'(b) :
               op == MULT ? 8'(a) * 8'(b) :
               op == DIV  ? (b == 4'h0 ? 8'h00 : 8'(a / b)) : 8'h00;
    endfunction

    assign bus.ula_result = ula(bus.ula_opcode, bus.ula_op1, bus.ula_op2);

    function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                       input logic sel, input logic [3:0] lo);
        return {op, rd, rs1, sel, 1'b0, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model the retire result at the moment of acceptance.
    always @(negedge clock) begin
        if (!reset && bus.in_valid && bus.in_ready) begin
            automatic logic [13:0] i = bus.instr;
            automatic logic [3:0]  a = mregs[i[7:6]];
            automatic logic [3:0]  b = i[5] ? i[3:0] : mregs[i[1:0]];
            automatic logic [7:0]  r = ula(i[13:10], a, b);
            automatic exp_t        e;
            n_acc++;
            if (i[13:10] == DIV && b == 4'h0) e = '{8'h00, 1'b0, 1'b0, 1'b1, cyc + 2};
            else begin
                e = '{r, r == 8'h00, r[7:4] != 4'h0, 1'b0, cyc + 2};
                mregs[i[9:8]] = r[3:0];
            end
            q.push_back(e);
        end
    end

    // done marks the retire cycle; wb_data/flags are visible one cycle later.
    exp_t pend;
    bit   have = 0;
    always @(negedge clock) begin
        if (reset) have = 0;
        else begin
            if (have) begin
                chk("wb_data", 32'(bus.wb_data), 32'(pend.wb));
                chk("flag_zero", 32'(bus.flag_zero), 32'(pend.fz));
                chk("flag_hi", 32'(bus.flag_hi), 32'(pend.fh));
                chk("flag_div0", 32'(bus.flag_div0), 32'(pend.fd));
                have = 0;
            end
            if (bus.done) begin
                n_done++;
                chk("done_has_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    pend = q.pop_front();
                    have = 1;
                    chk("latency", 32'(cyc), 32'(pend.due));
                end
            end
        end
    end

    task automatic issue(input logic [13:0] i);
        @(posedge clock); #1;
        bus.in_valid = 1'b1;
        bus.instr    = i;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            if (bus.in_ready) break;
            if (k == 10) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.instr    = 14'($urandom);
    endtask

    task automatic wait_retire();
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 4; r++) begin
            bus.dbg_addr = 2'(r);
            #1;
            chk($sformatf("%s_r%0d", tag, r), 32'(bus.dbg_data), 32'(mregs[r]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0;
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        bus.dbg_addr = '0;
        for (int r = 0; r < 4; r++) mregs[r] = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flags", 32'({bus.flag_zero, bus.flag_hi, bus.flag_div0}), 32'd0);
        chk("rst_wb", 32'(bus.wb_data), 32'd0);
        chk("rst_ula", 32'({bus.ula_op1, bus.ula_op2, bus.ula_opcode}), 32'd0);
        check_regs("rst");
        reset = 1'b0;

        issue(mk(ADD, 2'd1, 2'd0, 1'b1, 4'h7));
        wait_retire();
        issue(mk(ADD, 2'd2, 2'd1, 1'b1, 4'h9));
        wait_retire();
        chk("t2_wb", 32'(bus.wb_data), 32'h10);
        chk("t2_hi", 32'(bus.flag_hi), 32'd1);
        chk("t2_zero", 32'(bus.flag_zero), 32'd0);
        check_regs("t2");

        issue(mk(ADD, 2'd1, 2'd0, 1'b1, 4'h3));
        wait_retire();
        issue(mk(MULT, 2'd1, 2'd1, 1'b0, 4'h1));
        wait_retire();
        chk("t3_wb", 32'(bus.wb_data), 32'h09);
        check_regs("t3");

        d0 = n_done;
        issue(mk(DIV, 2'd3, 2'd1, 1'b1, 4'h0));
        wait_retire();
        chk("t4_div0", 32'(bus.flag_div0), 32'd1);
        chk("t4_wb", 32'(bus.wb_data), 32'h00);
        chk("t4_dones", 32'(n_done - d0), 32'd1);
        check_regs("t4");

        a0 = n_acc;
        @(posedge clock); #1;
        bus.in_valid = 1'b1;
        bus.instr    = mk(ADD, 2'd0, 2'd0, 1'b1, 4'h1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            chk($sformatf("t5_ready%0d", i), 32'(bus.in_ready), 32'(i % 3 == 0));
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        chk("t5_accepts", 32'(n_acc - a0), 32'd3);
        wait_retire();
        check_regs("t5");

        issue(mk(SUB, 2'd2, 2'd0, 1'b1, 4'h5));
        reset = 1'b1;
        q.delete();
        for (int r = 0; r < 4; r++) mregs[r] = 4'h0;
        d0 = n_done;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (4) @(posedge clock);
        #1;
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        chk("t6_wb", 32'(bus.wb_data), 32'd0);
        check_regs("t6");

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [13:0] i;
            op = ($urandom % 4 != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            i  = mk(op, 2'($urandom), 2'($urandom), 1'($urandom), 4'($urandom)) | 14'(($urandom % 2) << 4);
            issue(i);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        wait_retire();
        check_regs("rand");
        for (int k = 0; k < 20 && (q.size() != 0 || have); k++) @(posedge clock);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
